// File: rtl/pd_ana_trans_arbiter.sv
// Round-robin arbiter sharing one PD analog power stage between NUM_PORTS policy engines,
// with a shared current budget check and a completion watchdog.
module pd_ana_trans_arbiter #(
   parameter int          NUM_PORTS         = 2,
   parameter int          PORT_IDX_W        = 1,
   parameter logic [9:0]  TOTAL_CURRENT_MAX = 10'd500,
   parameter logic [15:0] TIMEOUT_CYC       = 16'd48000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_PORTS-1:0]    port_attached,
   input  logic [NUM_PORTS-1:0]    pe_trans_en,
   input  logic [NUM_PORTS-1:0]    pe_trans_pdotype,
   input  logic [NUM_PORTS*10-1:0] pe_trans_voltage,
   input  logic [NUM_PORTS*10-1:0] pe_trans_current,
   output logic [NUM_PORTS-1:0]    pe_trans_finish,
   output logic [NUM_PORTS-1:0]    pe_trans_reject,
   output logic                    ana_trans_en,
   output logic                    ana_trans_pdotype,
   output logic [9:0]              ana_trans_voltage,
   output logic [9:0]              ana_trans_current,
   output logic [PORT_IDX_W-1:0]   ana_trans_port,
   input  logic                    ana_trans_finish,
   output logic                    ana_timeout,
   output logic [12:0]             alloc_total
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                  state_r,    state_s;
   logic [NUM_PORTS-1:0]    pending_r,  pending_s;
   logic [9:0]              alloc_cur_r [NUM_PORTS];
   logic [9:0]              alloc_cur_s [NUM_PORTS];
   logic [PORT_IDX_W-1:0]   rr_ptr_r,   rr_ptr_s;
   logic [15:0]             wdog_r,     wdog_s;
   logic [PORT_IDX_W-1:0]   port_r,     port_s;
   logic                    pdotype_r,  pdotype_s;
   logic [9:0]              voltage_r,  voltage_s;
   logic [9:0]              current_r,  current_s;
   logic                    en_r,       en_s;
   logic                    fin_flag_r, fin_flag_s;
   logic                    rej_flag_r, rej_flag_s;
   logic                    lost_r,     lost_s;
   logic [NUM_PORTS-1:0]    pe_fin_r,   pe_fin_s;
   logic [NUM_PORTS-1:0]    pe_rej_r,   pe_rej_s;
   logic                    timeout_r,  timeout_s;
   logic [12:0]             alloc_total_r;
   logic [12:0]             alloc_sum_s;
   logic [12:0]             need_s;
   logic [2*NUM_PORTS-1:0]  rot_s;
   logic                    grant_vld_s;
   logic [PORT_IDX_W-1:0]   grant_idx_s;
   int                      grant_off_s;
   int                      grant_sum_s;

   // Round-robin search: first pending port at or after rr_ptr, wrapping.
   always_comb begin
      rot_s       = {pending_r, pending_r} >> rr_ptr_r;
      grant_vld_s = 1'b0;
      grant_off_s = 0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (rot_s[k]) begin
            grant_vld_s = 1'b1;
            grant_off_s = k;
         end else begin
            grant_vld_s = grant_vld_s;
            grant_off_s = grant_off_s;
         end
      end
      grant_sum_s = int'(rr_ptr_r) + grant_off_s;
      if (grant_sum_s >= NUM_PORTS) begin
         grant_sum_s = grant_sum_s - NUM_PORTS;
      end else begin
         grant_sum_s = grant_sum_s;
      end
      grant_idx_s = PORT_IDX_W'(grant_sum_s);
   end

   // Sum of per-port allocations, registered into alloc_total one cycle later.
   always_comb begin
      alloc_sum_s = 13'd0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         alloc_sum_s = alloc_sum_s + {3'b000, alloc_cur_r[k]};
      end
   end

   // Budget need with the granted port's current allocation replaced by its new request.
   assign need_s = alloc_total_r - {3'b000, alloc_cur_r[port_r]} + {3'b000, current_r};

   // Next-state, request capture, allocation and pulse generation.
   always_comb begin
      state_s    = state_r;
      pending_s  = pending_r;
      alloc_cur_s = alloc_cur_r;
      rr_ptr_s   = rr_ptr_r;
      wdog_s     = wdog_r;
      port_s     = port_r;
      pdotype_s  = pdotype_r;
      voltage_s  = voltage_r;
      current_s  = current_r;
      en_s       = en_r;
      fin_flag_s = fin_flag_r;
      rej_flag_s = rej_flag_r;
      lost_s     = lost_r | ((state_r != ST_IDLE) && !port_attached[port_r]);
      pe_fin_s   = '0;
      pe_rej_s   = '0;
      timeout_s  = 1'b0;

      for (int i = 0; i < NUM_PORTS; i++) begin
         if (pe_trans_en[i] && port_attached[i] && !pending_r[i] &&
             !((state_r != ST_IDLE) && (port_r == PORT_IDX_W'(i)))) begin
            pending_s[i] = 1'b1;
         end else begin
            pending_s[i] = pending_s[i];
         end
      end

      case (state_r)
         ST_IDLE: begin
            if (grant_vld_s) begin
               pending_s[grant_idx_s] = 1'b0;
               port_s     = grant_idx_s;
               fin_flag_s = 1'b0;
               rej_flag_s = 1'b0;
               lost_s     = 1'b0;
               state_s    = ST_CHECK;
               for (int i = 0; i < NUM_PORTS; i++) begin
                  if (grant_idx_s == PORT_IDX_W'(i)) begin
                     pdotype_s = pe_trans_pdotype[i];
                     voltage_s = pe_trans_voltage[10*i +: 10];
                     current_s = pe_trans_current[10*i +: 10];
                  end else begin
                     pdotype_s = pdotype_s;
                     voltage_s = voltage_s;
                     current_s = current_s;
                  end
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_CHECK: begin
            if (need_s > {3'b000, TOTAL_CURRENT_MAX}) begin
               rej_flag_s = 1'b1;
               state_s    = ST_DONE;
            end else begin
               en_s    = 1'b1;
               wdog_s  = 16'd0;
               state_s = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (ana_trans_finish) begin
               // A port that detached mid-transaction keeps a zero allocation.
               en_s       = 1'b0;
               fin_flag_s = 1'b1;
               state_s    = ST_DONE;
               if (!lost_r) begin
                  alloc_cur_s[port_r] = current_r;
               end else begin
                  alloc_cur_s[port_r] = alloc_cur_s[port_r];
               end
            end else if (wdog_r == (TIMEOUT_CYC - 16'd1)) begin
               en_s       = 1'b0;
               timeout_s  = 1'b1;
               rej_flag_s = 1'b1;
               state_s    = ST_DONE;
            end else begin
               wdog_s = wdog_r + 16'd1;
            end
         end
         ST_DONE: begin
            if (lost_s) begin
               pe_fin_s = '0;
            end else if (fin_flag_r) begin
               pe_fin_s[port_r] = 1'b1;
            end else if (rej_flag_r) begin
               pe_rej_s[port_r] = 1'b1;
            end else begin
               pe_fin_s = '0;
            end
            rr_ptr_s = (port_r == PORT_IDX_W'(NUM_PORTS - 1)) ? '0 : port_r + PORT_IDX_W'(1);
            state_s  = ST_IDLE;
         end
         default: begin
            en_s    = 1'b0;
            state_s = ST_IDLE;
         end
      endcase

      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!port_attached[i]) begin
            pending_s[i]   = 1'b0;
            alloc_cur_s[i] = 10'd0;
         end else begin
            pending_s[i]   = pending_s[i];
            alloc_cur_s[i] = alloc_cur_s[i];
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         pending_r     <= '0;
         for (int k = 0; k < NUM_PORTS; k++) begin
            alloc_cur_r[k] <= 10'd0;
         end
         rr_ptr_r      <= '0;
         wdog_r        <= 16'd0;
         port_r        <= '0;
         pdotype_r     <= 1'b0;
         voltage_r     <= 10'd0;
         current_r     <= 10'd0;
         en_r          <= 1'b0;
         fin_flag_r    <= 1'b0;
         rej_flag_r    <= 1'b0;
         lost_r        <= 1'b0;
         pe_fin_r      <= '0;
         pe_rej_r      <= '0;
         timeout_r     <= 1'b0;
         alloc_total_r <= 13'd0;
      end else begin
         state_r       <= state_s;
         pending_r     <= pending_s;
         alloc_cur_r   <= alloc_cur_s;
         rr_ptr_r      <= rr_ptr_s;
         wdog_r        <= wdog_s;
         port_r        <= port_s;
         pdotype_r     <= pdotype_s;
         voltage_r     <= voltage_s;
         current_r     <= current_s;
         en_r          <= en_s;
         fin_flag_r    <= fin_flag_s;
         rej_flag_r    <= rej_flag_s;
         lost_r        <= lost_s;
         pe_fin_r      <= pe_fin_s;
         pe_rej_r      <= pe_rej_s;
         timeout_r     <= timeout_s;
         alloc_total_r <= alloc_sum_s;
      end
   end

   assign pe_trans_finish   = pe_fin_r;
   assign pe_trans_reject   = pe_rej_r;
   assign ana_trans_en      = en_r;
   assign ana_trans_pdotype = pdotype_r;
   assign ana_trans_voltage = voltage_r;
   assign ana_trans_current = current_r;
   assign ana_trans_port    = port_r;
   assign ana_timeout       = timeout_r;
   assign alloc_total       = alloc_total_r;

endmodule

// File: tb/tb_pd_ana_trans_arbiter.sv
// Directed plus randomized bench for pd_ana_trans_arbiter; expectations come from a
// per-port allocation model and the request/grant/CHECK/WAIT/DONE timing rules.
module tb_pd_ana_trans_arbiter;

   localparam int N      = 2;
   localparam int TO     = 16;
   localparam int BUDGET = 500;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    port_attached;
   logic [N-1:0]    pe_trans_en;
   logic [N-1:0]    pe_trans_pdotype;
   logic [N*10-1:0] pe_trans_voltage;
   logic [N*10-1:0] pe_trans_current;
   logic [N-1:0]    pe_trans_finish;
   logic [N-1:0]    pe_trans_reject;
   logic            ana_trans_en;
   logic            ana_trans_pdotype;
   logic [9:0]      ana_trans_voltage;
   logic [9:0]      ana_trans_current;
   logic [0:0]      ana_trans_port;
   logic            ana_trans_finish;
   logic            ana_timeout;
   logic [12:0]     alloc_total;

   int         vectors = 0;
   int         miscompares = 0;
   int         m_alloc [N];
   int         m_rr;
   logic [9:0] v_arr [N];
   logic [9:0] c_arr [N];
   logic       pdo_arr [N];

   pd_ana_trans_arbiter #(
      .NUM_PORTS(N), .PORT_IDX_W(1), .TOTAL_CURRENT_MAX(10'd500), .TIMEOUT_CYC(16'd16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .port_attached(port_attached), .pe_trans_en(pe_trans_en),
      .pe_trans_pdotype(pe_trans_pdotype), .pe_trans_voltage(pe_trans_voltage),
      .pe_trans_current(pe_trans_current), .pe_trans_finish(pe_trans_finish),
      .pe_trans_reject(pe_trans_reject), .ana_trans_en(ana_trans_en),
      .ana_trans_pdotype(ana_trans_pdotype), .ana_trans_voltage(ana_trans_voltage),
      .ana_trans_current(ana_trans_current), .ana_trans_port(ana_trans_port),
      .ana_trans_finish(ana_trans_finish), .ana_timeout(ana_timeout), .alloc_total(alloc_total)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int msum();
      int s = 0;
      for (int k = 0; k < N; k++) s += m_alloc[k];
      return s;
   endfunction

   function automatic int pick(input logic [N-1:0] pend);
      for (int k = 0; k < N; k++) begin
         int idx = (m_rr + k) % N;
         if (pend[idx]) return idx;
      end
      return 0;
   endfunction

   task automatic load(input int p, input logic pdo, input logic [9:0] v, input logic [9:0] c);
      pdo_arr[p] = pdo;
      v_arr[p]   = v;
      c_arr[p]   = c;
      pe_trans_pdotype[p]          = pdo;
      pe_trans_voltage[10*p +: 10] = v;
      pe_trans_current[10*p +: 10] = c;
   endtask

   // Called in the IDLE cycle where port p is pending; returns in the cycle after DONE.
   task automatic serve(input int p, input int fin_after, input bit detach_mid);
      int         need;
      bit         accept, finished, timed_out, det;
      logic [N-1:0] onehot;
      onehot = '0;
      onehot[p] = 1'b1;
      finished = 1'b0; timed_out = 1'b0; det = 1'b0;
      tick();
      tick();
      need   = msum() - m_alloc[p] + int'(c_arr[p]);
      accept = (need <= BUDGET);
      chk("en_after_check", 32'(ana_trans_en), 32'(accept));
      chk("grant_port", 32'(ana_trans_port), 32'(p));
      chk("grant_voltage", 32'(ana_trans_voltage), 32'(v_arr[p]));
      chk("grant_current", 32'(ana_trans_current), 32'(c_arr[p]));
      chk("grant_pdotype", 32'(ana_trans_pdotype), 32'(pdo_arr[p]));
      if (accept) begin
         for (int w = 1; w <= TO; w++) begin
            chk("en_hold", 32'(ana_trans_en), 32'd1);
            if (detach_mid && w == 2) begin
               port_attached[p] = 1'b0;
               det = 1'b1;
            end
            if (w == fin_after) begin
               ana_trans_finish = 1'b1;
               tick();
               ana_trans_finish = 1'b0;
               finished = 1'b1;
               break;
            end
            tick();
            if (w == TO) timed_out = 1'b1;
         end
         chk("en_drop", 32'(ana_trans_en), 32'd0);
         chk("timeout_pulse", 32'(ana_timeout), 32'(timed_out));
      end else begin
         chk("timeout_idle", 32'(ana_timeout), 32'd0);
      end
      tick();
      if (det) m_alloc[p] = 0;
      else if (finished) m_alloc[p] = int'(c_arr[p]);
      chk("finish_pulse", 32'(pe_trans_finish), (finished && !det) ? 32'(onehot) : 32'd0);
      chk("reject_pulse", 32'(pe_trans_reject),
          ((timed_out || !accept) && !det) ? 32'(onehot) : 32'd0);
      chk("timeout_clear", 32'(ana_timeout), 32'd0);
      chk("alloc_total", 32'(alloc_total), 32'(msum()));
      m_rr = (p + 1) % N;
   endtask

   task automatic run_txn(input int p, input logic pdo, input logic [9:0] v,
                          input logic [9:0] c, input int fin_after, input bit detach_mid);
      load(p, pdo, v, c);
      pe_trans_en[p] = 1'b1;
      tick();
      pe_trans_en = '0;
      serve(p, fin_after, detach_mid);
      tick();
      chk("finish_clear", 32'(pe_trans_finish), 32'd0);
      chk("reject_clear", 32'(pe_trans_reject), 32'd0);
      if (detach_mid) begin
         port_attached[p] = 1'b1;
         tick();
      end
   endtask

   task automatic run_pair(input logic [9:0] c0, input logic [9:0] c1);
      int first;
      int second;
      load(0, 1'b0, 10'd500, c0);
      load(1, 1'b1, 10'd420, c1);
      pe_trans_en = 2'b11;
      tick();
      pe_trans_en = '0;
      first = pick(2'b11);
      serve(first, 3, 1'b0);
      second = pick(first == 0 ? 2'b10 : 2'b01);
      serve(second, 4, 1'b0);
      tick();
      chk("pair_finish_clear", 32'(pe_trans_finish), 32'd0);
   endtask

   initial begin
      port_attached = '0; pe_trans_en = '0; pe_trans_pdotype = '0;
      pe_trans_voltage = '0; pe_trans_current = '0; ana_trans_finish = 1'b0;
      for (int k = 0; k < N; k++) m_alloc[k] = 0;
      m_rr = 0;
      tick();
      tick();
      chk("rst_en", 32'(ana_trans_en), 32'd0);
      chk("rst_port", 32'(ana_trans_port), 32'd0);
      chk("rst_voltage", 32'(ana_trans_voltage), 32'd0);
      chk("rst_current", 32'(ana_trans_current), 32'd0);
      chk("rst_pdotype", 32'(ana_trans_pdotype), 32'd0);
      chk("rst_finish", 32'(pe_trans_finish), 32'd0);
      chk("rst_reject", 32'(pe_trans_reject), 32'd0);
      chk("rst_timeout", 32'(ana_timeout), 32'd0);
      chk("rst_alloc", 32'(alloc_total), 32'd0);
      port_attached = 2'b11;
      rst_n = 1'b1;
      tick();

      // Single port 9 V / 3 A, then budget reject and re-request.
      run_txn(0, 1'b0, 10'd900, 10'd300, 10, 1'b0);
      run_txn(1, 1'b0, 10'd500, 10'd250, 5, 1'b0);
      run_txn(0, 1'b0, 10'd500, 10'd200, 6, 1'b0);
      // Leave rr at 0, contend, then leave rr at 1 and contend again.
      run_txn(1, 1'b0, 10'd500, 10'd100, 3, 1'b0);
      run_pair(10'd150, 10'd100);
      run_txn(0, 1'b0, 10'd500, 10'd120, 2, 1'b0);
      run_pair(10'd130, 10'd90);

      // Stray analog finish while idle.
      ana_trans_finish = 1'b1;
      tick();
      ana_trans_finish = 1'b0;
      tick();
      chk("stray_en", 32'(ana_trans_en), 32'd0);
      chk("stray_finish", 32'(pe_trans_finish), 32'd0);
      chk("stray_alloc", 32'(alloc_total), 32'(msum()));

      // Finish on the last watchdog cycle, pure timeout, detach mid-WAIT.
      run_txn(0, 1'b1, 10'd420, 10'd50, TO, 1'b0);
      run_txn(1, 1'b0, 10'd500, 10'd60, 0, 1'b0);
      run_txn(1, 1'b0, 10'd500, 10'd70, 8, 1'b1);

      // A detached port's request pulse is ignored and its allocation cleared.
      port_attached[0] = 1'b0;
      m_alloc[0] = 0;
      tick();
      pe_trans_en[0] = 1'b1;
      tick();
      pe_trans_en = '0;
      tick();
      tick();
      chk("detached_req_en", 32'(ana_trans_en), 32'd0);
      chk("detached_alloc", 32'(alloc_total), 32'(msum()));
      port_attached[0] = 1'b1;
      tick();

      for (int it = 0; it < 24; it++) begin
         int p, fin;
         bit det;
         p   = int'($urandom_range(0, N - 1));
         fin = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO));
         det = ($urandom_range(0, 5) == 0);
         run_txn(p, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
                 10'($urandom_range(0, 450)), fin, det);
      end

      // Asynchronous reset while the analog request is held.
      load(0, 1'b0, 10'd500, 10'd0);
      pe_trans_en[0] = 1'b1;
      tick();
      pe_trans_en = '0;
      tick();
      tick();
      tick();
      chk("pre_rst_en", 32'(ana_trans_en), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_en", 32'(ana_trans_en), 32'd0);
      chk("async_rst_alloc", 32'(alloc_total), 32'd0);
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < N; k++) m_alloc[k] = 0;
      m_rr = 0;
      tick();
      chk("post_rst_en", 32'(ana_trans_en), 32'd0);
      chk("post_rst_finish", 32'(pe_trans_finish), 32'd0);
      chk("post_rst_reject", 32'(pe_trans_reject), 32'd0);
      run_txn(1, 1'b1, 10'd330, 10'd300, 4, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
